// File: rtl/elevator_ctrl_module_if.sv
// Request/status bundle between the car controller and the button logic.
// The master side supplies the relative request vectors and door_hold;
// the slave side (the car controller) returns position, motion, direction,
// door state and the hall-call serve pulses.
interface elevator_ctrl_module_if;
  logic [2:0] ctrl_button_up;
  logic [2:0] ctrl_button_down;
  logic [2:0] ctrl_button_in;
  logic       door_hold;
  logic [1:0] position;
  logic       open;
  logic       moving;
  logic       dir_up;
  logic       dir_down;
  logic       serve_up;
  logic       serve_down;

  modport master (
    output ctrl_button_up, ctrl_button_down, ctrl_button_in, door_hold,
    input  position, open, moving, dir_up, dir_down, serve_up, serve_down
  );

  modport slave (
    input  ctrl_button_up, ctrl_button_down, ctrl_button_in, door_hold,
    output position, open, moving, dir_up, dir_down, serve_up, serve_down
  );
endinterface

// File: rtl/elevator_ctrl_module.sv
// Car controller for a 4-floor elevator.
// Request vectors are relative to the car: bit0 = here, bit1 = above,
// bit2 = below. The controller moves the car one floor per TRAVEL_CYCLES,
// decides at each arrival whether to stop, and holds the door open for
// DOOR_CYCLES. Hall calls at the stop floor are acknowledged with 1-cycle
// serve pulses.
// Optional feature: define DOOR_HOLD_EN to let door_hold freeze the door
// timer; without it door_hold is ignored.
module elevator_ctrl_module #(
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 4
) (
  input logic                  clk,
  input logic                  reset_n,
  elevator_ctrl_module_if.slave bus
);

  localparam int MAXC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [2:0] {IDLE, MOVE_UP, MOVE_DOWN, ARRIVE, DOOR_OPEN} state_t;

  state_t        state_reg;
  logic [TW-1:0] timer_reg;
  logic [1:0]    pos_reg;
  logic          open_reg, moving_reg, dir_up_reg, dir_down_reg;
  logic          serve_up_reg, serve_down_reg;
  logic [2:0]    here_prev_reg;

  // Combined request summary: {car, up hall, down hall} at this floor
  logic [2:0] here_vec;
  logic       here, above, below;
  assign here_vec = {bus.ctrl_button_in[0], bus.ctrl_button_up[0], bus.ctrl_button_down[0]};
  assign here     = |here_vec;
  assign above    = bus.ctrl_button_in[1] | bus.ctrl_button_up[1] | bus.ctrl_button_down[1];
  assign below    = bus.ctrl_button_in[2] | bus.ctrl_button_up[2] | bus.ctrl_button_down[2];

`ifdef DOOR_HOLD_EN
  logic hold;
  assign hold = bus.door_hold;
`else
  logic hold;
  logic unused_door_hold;
  assign hold             = 1'b0;
  assign unused_door_hold = bus.door_hold;
`endif

  // Arrival decision: stop or not, and the direction committed on a stop
  logic same_hall, opp_hall, ahead, behind, at_end, stop;
  logic new_up, new_down;
  always_comb begin
    same_hall = dir_up_reg ? bus.ctrl_button_up[0]   : bus.ctrl_button_down[0];
    opp_hall  = dir_up_reg ? bus.ctrl_button_down[0] : bus.ctrl_button_up[0];
    ahead     = dir_up_reg ? above : below;
    behind    = dir_up_reg ? below : above;
    at_end    = dir_up_reg ? (pos_reg == 2'd3) : (pos_reg == 2'd0);
    stop      = bus.ctrl_button_in[0] | same_hall | (opp_hall & ~ahead) | at_end;
    new_up    = 1'b0;
    new_down  = 1'b0;
    if (ahead) begin
      new_up   = dir_up_reg;
      new_down = ~dir_up_reg;
    end else if (behind | opp_hall) begin
      new_up   = ~dir_up_reg;
      new_down = dir_up_reg;
    end
  end

  // Main car FSM with registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      timer_reg      <= '0;
      pos_reg        <= 2'd0;
      open_reg       <= 1'b0;
      moving_reg     <= 1'b0;
      dir_up_reg     <= 1'b0;
      dir_down_reg   <= 1'b0;
      serve_up_reg   <= 1'b0;
      serve_down_reg <= 1'b0;
      here_prev_reg  <= 3'b000;
    end else begin
      serve_up_reg   <= 1'b0;
      serve_down_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (here) begin
            // No committed direction here, so either hall call is served
            state_reg      <= DOOR_OPEN;
            open_reg       <= 1'b1;
            timer_reg      <= '0;
            dir_up_reg     <= 1'b0;
            dir_down_reg   <= 1'b0;
            serve_up_reg   <= bus.ctrl_button_up[0];
            serve_down_reg <= bus.ctrl_button_down[0];
            here_prev_reg  <= here_vec;
          end else if (above && pos_reg != 2'd3) begin
            state_reg    <= MOVE_UP;
            moving_reg   <= 1'b1;
            timer_reg    <= '0;
            dir_up_reg   <= 1'b1;
            dir_down_reg <= 1'b0;
          end else if (below && pos_reg != 2'd0) begin
            state_reg    <= MOVE_DOWN;
            moving_reg   <= 1'b1;
            timer_reg    <= '0;
            dir_up_reg   <= 1'b0;
            dir_down_reg <= 1'b1;
          end else begin
            dir_up_reg   <= 1'b0;
            dir_down_reg <= 1'b0;
          end
        end
        MOVE_UP, MOVE_DOWN: begin
          if (timer_reg == TW'(TRAVEL_CYCLES - 1)) begin
            if (state_reg == MOVE_UP && pos_reg != 2'd3) pos_reg <= pos_reg + 2'd1;
            if (state_reg == MOVE_DOWN && pos_reg != 2'd0) pos_reg <= pos_reg - 2'd1;
            state_reg  <= ARRIVE;
            moving_reg <= 1'b0;
            timer_reg  <= '0;
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        ARRIVE: begin
          if (stop) begin
            state_reg      <= DOOR_OPEN;
            open_reg       <= 1'b1;
            timer_reg      <= '0;
            dir_up_reg     <= new_up;
            dir_down_reg   <= new_down;
            serve_up_reg   <= bus.ctrl_button_up[0] & ~new_down;
            serve_down_reg <= bus.ctrl_button_down[0] & ~new_up;
            here_prev_reg  <= here_vec;
          end else begin
            state_reg  <= dir_up_reg ? MOVE_UP : MOVE_DOWN;
            moving_reg <= 1'b1;
            timer_reg  <= '0;
          end
        end
        DOOR_OPEN: begin
          here_prev_reg <= here_vec;
          // Only a call that newly appears at this floor restarts the door
          if (|(here_vec & ~here_prev_reg)) begin
            timer_reg      <= '0;
            serve_up_reg   <= bus.ctrl_button_up[0] & ~dir_down_reg;
            serve_down_reg <= bus.ctrl_button_down[0] & ~dir_up_reg;
          end else if (hold) begin
            timer_reg <= '0;
          end else if (timer_reg == TW'(DOOR_CYCLES - 1)) begin
            open_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.position   = pos_reg;
  assign bus.open       = open_reg;
  assign bus.moving     = moving_reg;
  assign bus.dir_up     = dir_up_reg;
  assign bus.dir_down   = dir_down_reg;
  assign bus.serve_up   = serve_up_reg;
  assign bus.serve_down = serve_down_reg;

endmodule

// File: tb/tb_elevator_ctrl_module.sv
// Bench for elevator_ctrl_module. A small button model turns absolute
// floor calls into relative request vectors and clears calls when served.
// Expected position/door/serve events are queued with their cycle when a
// request is issued and matched against what the car does.
module tb_elevator_ctrl_module;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  elevator_ctrl_module_if bus();

  elevator_ctrl_module #(.TRAVEL_CYCLES(8), .DOOR_CYCLES(4)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  logic [3:0] car_call, hall_up, hall_dn;

  function automatic logic [2:0] rel(input logic [3:0] calls, input logic [1:0] pos);
    logic [2:0] r;
    r = 3'b000;
    for (int f = 0; f < 4; f++) begin
      if (calls[f]) begin
        if (f == int'(pos)) r[0] = 1'b1;
        else if (f > int'(pos)) r[1] = 1'b1;
        else r[2] = 1'b1;
      end
    end
    return r;
  endfunction

  always_comb begin
    bus.ctrl_button_in   = rel(car_call, bus.position);
    bus.ctrl_button_up   = rel(hall_up, bus.position);
    bus.ctrl_button_down = rel(hall_dn, bus.position);
  end

  // kinds: 0 position change, 1 door opens, 2 door closes, 3 serve_up, 4 serve_down
  typedef struct packed {
    logic [3:0]  kind;
    logic [31:0] cyc;
    logic [3:0]  val;
  } ev_t;
  ev_t sb[$];

  int cyc, checks, errors, base;
  logic [1:0] prev_pos;
  logic       prev_open;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_ev(input int k, input int c, input int v);
    ev_t e;
    e.kind = 4'(k);
    e.cyc  = 32'(c);
    e.val  = 4'(v);
    sb.push_back(e);
  endtask

  task automatic observe(input int k);
    ev_t got, want;
    got.kind = 4'(k);
    got.cyc  = 32'(cyc);
    got.val  = {2'b00, bus.position};
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL stray_event observed kind=%0d cyc=%0d pos=%0d expected none", k, cyc, bus.position);
    end
    if (sb.size() != 0) begin
      want = sb.pop_front();
      checks++;
      assert (got === want) else begin
        errors++;
        $error("FAIL event observed kind=%0d cyc=%0d pos=%0d expected kind=%0d cyc=%0d pos=%0d",
               got.kind, got.cyc, got.val, want.kind, want.cyc, want.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    chk("moving_open_excl", 32'(bus.moving & bus.open), 32'd0);
    chk("dir_excl", 32'(bus.dir_up & bus.dir_down), 32'd0);
    if (bus.position != prev_pos) observe(0);
    if (bus.open && !prev_open) observe(1);
    if (!bus.open && prev_open) observe(2);
    if (bus.serve_up) observe(3);
    if (bus.serve_down) observe(4);
    prev_pos  = bus.position;
    prev_open = bus.open;
    if (bus.open) car_call[bus.position] = 1'b0;
    if (bus.serve_up) hall_up[bus.position] = 1'b0;
    if (bus.serve_down) hall_dn[bus.position] = 1'b0;
    for (int i = 0; i < 1; i++) begin end
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) step();
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL drain_timeout observed pending=%0d expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    reset_n = 1'b0;
    car_call = 4'b0; hall_up = 4'b0; hall_dn = 4'b0;
    bus.door_hold = 1'b0;
    cyc = 0; checks = 0; errors = 0;
    prev_pos = 2'd0; prev_open = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 32'({bus.position, bus.open, bus.moving, bus.dir_up, bus.dir_down,
                            bus.serve_up, bus.serve_down}), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    step();

    // Reset while moving up at floor 1
    base = cyc; car_call[3] = 1'b1;
    expect_ev(0, base + 9, 1);
    drain(50);
    step(); step();
    chk("t1_moving", 32'({bus.moving, bus.open}), 32'b10);
    #2 reset_n = 1'b0;
    #1;
    chk("t1_async_reset", 32'({bus.position, bus.open, bus.moving, bus.dir_up, bus.dir_down,
                               bus.serve_up, bus.serve_down}), 32'd0);
    car_call = 4'b0; prev_pos = 2'd0; prev_open = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    step();
    chk("t1_after_reset_pos", 32'(bus.position), 32'd0);

    // Car call at the current floor: door open 4 cycles
    base = cyc; car_call[0] = 1'b1;
    expect_ev(1, base + 1, 0);
    expect_ev(2, base + 5, 0);
    drain(30);
    step();
    chk("t2_idle", 32'({bus.open, bus.moving}), 32'd0);

    // Up hall call at floor 2
    base = cyc; hall_up[2] = 1'b1;
    expect_ev(0, base + 9, 1);
    expect_ev(0, base + 18, 2);
    expect_ev(1, base + 19, 2);
    expect_ev(3, base + 19, 2);
    expect_ev(2, base + 23, 2);
    drain(60);

    // Return to floor 0
    base = cyc; car_call[0] = 1'b1;
    expect_ev(0, base + 9, 1);
    expect_ev(0, base + 18, 0);
    expect_ev(1, base + 19, 0);
    expect_ev(2, base + 23, 0);
    drain(60);

    // Down call at 2 skipped on the way up to car call at 3, then served
    base = cyc; car_call[3] = 1'b1; hall_dn[2] = 1'b1;
    expect_ev(0, base + 9, 1);
    expect_ev(0, base + 18, 2);
    expect_ev(0, base + 27, 3);
    expect_ev(1, base + 28, 3);
    drain(60);
    chk("t4_dir_flip", 32'({bus.dir_up, bus.dir_down}), 32'b01);
    expect_ev(2, base + 32, 3);
    expect_ev(0, base + 41, 2);
    expect_ev(1, base + 42, 2);
    expect_ev(4, base + 42, 2);
    expect_ev(2, base + 46, 2);
    drain(60);
    chk("t4_dir_none", 32'({bus.dir_up, bus.dir_down}), 32'b00);

    // Top floor going up with only a down call there
    base = cyc; hall_dn[3] = 1'b1;
    expect_ev(0, base + 9, 3);
    expect_ev(1, base + 10, 3);
    expect_ev(4, base + 10, 3);
    drain(40);
    chk("t5_dir_down", 32'({bus.dir_up, bus.dir_down}), 32'b01);
    expect_ev(2, base + 14, 3);
    drain(20);
    step(); step(); step();
    chk("t5_pos_kept", 32'(bus.position), 32'd3);
    chk("t5_dir_none", 32'({bus.dir_up, bus.dir_down}), 32'b00);

    // Door hold for 20 cycles
    base = cyc; car_call[3] = 1'b1; bus.door_hold = 1'b1;
    expect_ev(1, base + 1, 3);
`ifdef DOOR_HOLD_EN
    expect_ev(2, base + 24, 3);
`else
    expect_ev(2, base + 5, 3);
`endif
    while (cyc < base + 20) step();
`ifdef DOOR_HOLD_EN
    chk("t6_open_held", 32'(bus.open), 32'd1);
`else
    chk("t6_open_held", 32'(bus.open), 32'd0);
`endif
    bus.door_hold = 1'b0;
    drain(30);
    step(); step();
    chk("t6_closed", 32'({bus.open, bus.moving}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
